snoop_bus_sequencer: RTL and testbench

Central controller for the snooping MESI bus. Arbitrates round-robin among NUM_PROC processor requests and grants one requester per bus transaction. Drives the shared 3-bit step code through the six-phase cache protocol, advancing on the caches' stepNDone/instrDone handshakes. Clears cache handshake flags between transactions and flags hung steps by timeout.

---
 rtl/snoop_bus_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_snoop_bus_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_sequencer.sv
// Snoop bus sequencer: round-robin arbiter plus six-phase MESI step driver with per-step timeout.
// All outputs are registered and loaded from the next-state decode, so they line up with the state.
module snoop_bus_sequencer #(
    parameter int NUM_PROC = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NUM_PROC-1:0]    req_i,
    input  logic [NUM_PROC-1:0]    req_write_i,
    input  logic [12*NUM_PROC-1:0] tag_req_i,
    input  logic [5*NUM_PROC-1:0]  step_done_i,
    input  logic [NUM_PROC-1:0]    instr_done_i,
    output logic [2:0]             step_o,
    output logic                   cache_reset_o,
    output logic [NUM_PROC-1:0]    grant_o,
    output logic [NUM_PROC-1:0]    read_out_o,
    output logic [NUM_PROC-1:0]    write_out_o,
    output logic [11:0]            tag_bus_out_o,
    output logic [NUM_PROC-1:0]    ack_o,
    output logic                   busy_o,
    output logic                   bus_error_o
);

    localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    // state  | meaning
    // IDLE   | waiting for a request, arbitrates on exit
    // CLR    | one-cycle cache handshake clear
    // S1..S6 | protocol step k broadcast, waiting on cache dones
    // FINISH | ack to owner, release bus
    typedef enum logic [3:0] {
        IDLE, CLR, S1, S2, S3, S4, S5, S6, FINISH
    } state_t;

    state_t              state_q, state_d, nxt;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic [PW-1:0]       idx_q, idx_d;
    logic [NUM_PROC-1:0] grant_q, grant_d;
    logic [NUM_PROC-1:0] rd_q, rd_d;
    logic [NUM_PROC-1:0] wr_q, wr_d;
    logic [NUM_PROC-1:0] ack_q, ack_d;
    logic [11:0]         tag_q, tag_d;
    logic [2:0]          step_q, step_d;
    logic                crst_q, crst_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                snoop1, snoop3, snoop4;
    logic                own2, own5, own_instr;
    logic                found;
    logic [PW-1:0]       win;
    logic [NUM_PROC-1:0] win_oh;
    logic [11:0]         win_tag;
    logic                adv;
    logic                in_step;

    // Snoop phases need every cache; owner phases look only at the granted cache.
    always_comb begin
        snoop1    = 1'b1;
        snoop3    = 1'b1;
        snoop4    = 1'b1;
        own2      = 1'b0;
        own5      = 1'b0;
        own_instr = 1'b0;
        for (int p = 0; p < NUM_PROC; p++) begin
            snoop1 = snoop1 & step_done_i[5*p+0];
            snoop3 = snoop3 & step_done_i[5*p+2];
            snoop4 = snoop4 & step_done_i[5*p+3];
            if (idx_q == PW'(p)) begin
                own2      = step_done_i[5*p+1];
                own5      = step_done_i[5*p+4];
                own_instr = instr_done_i[p];
            end
        end
    end

    // Search starts one past the last owner and wraps.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_oh  = '0;
        win_tag = '0;
        for (int i = 1; i <= NUM_PROC; i++) begin
            for (int p = 0; p < NUM_PROC; p++) begin
                if (!found && req_i[p] && (((int'(rr_q) + i) % NUM_PROC) == p)) begin
                    found     = 1'b1;
                    win       = PW'(p);
                    win_oh[p] = 1'b1;
                    win_tag   = tag_req_i[12*p +: 12];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        err_d   = err_q;
        adv     = 1'b0;
        nxt     = state_q;
        in_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = CLR;
                    idx_d   = win;
                    grant_d = win_oh;
                    rd_d    = win_oh & ~req_write_i;
                    wr_d    = win_oh & req_write_i;
                    tag_d   = win_tag;
                    busy_d  = 1'b1;
                end
            end
            CLR: state_d = S1;
            S1: begin
                in_step = 1'b1;
                adv     = snoop1;
                nxt     = S2;
            end
            S2: begin
                in_step = 1'b1;
                adv     = own2;
                nxt     = own_instr ? FINISH : S3;
            end
            S3: begin
                in_step = 1'b1;
                adv     = snoop3;
                nxt     = S4;
            end
            S4: begin
                in_step = 1'b1;
                adv     = snoop4;
                nxt     = S5;
            end
            S5: begin
                in_step = 1'b1;
                adv     = own5;
                nxt     = S6;
            end
            S6: begin
                in_step = 1'b1;
                adv     = own_instr;
                nxt     = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
                rr_d    = idx_q;
                grant_d = '0;
                rd_d    = '0;
                wr_d    = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                rd_d    = '0;
                wr_d    = '0;
                busy_d  = 1'b0;
            end
        endcase

        // A done that lands on the last allowed cycle still advances.
        if (in_step) begin
            if (adv) begin
                state_d = nxt;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = FINISH;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        case (state_d)
            S1:      step_d = 3'd1;
            S2:      step_d = 3'd2;
            S3:      step_d = 3'd3;
            S4:      step_d = 3'd4;
            S5:      step_d = 3'd5;
            S6:      step_d = 3'd6;
            default: step_d = 3'd0;
        endcase
        crst_d = (state_d == CLR);
        ack_d  = (state_d == FINISH && state_q != FINISH) ? grant_q : '0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= PW'(NUM_PROC - 1);
            idx_q   <= '0;
            grant_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            ack_q   <= '0;
            tag_q   <= '0;
            step_q  <= 3'd0;
            crst_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            tag_q   <= tag_d;
            step_q  <= step_d;
            crst_q  <= crst_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign step_o        = step_q;
    assign cache_reset_o = crst_q;
    assign grant_o       = grant_q;
    assign read_out_o    = rd_q;
    assign write_out_o   = wr_q;
    assign tag_bus_out_o = tag_q;
    assign ack_o         = ack_q;
    assign busy_o        = busy_q;
    assign bus_error_o   = err_q;

endmodule

// File: tb/tb_snoop_bus_sequencer.sv
// Bench for snoop_bus_sequencer: responder caches with programmable done latency and a
// per-transaction model predicting winner, step sequence, duration and error flag.
module tb_snoop_bus_sequencer;

    localparam int NP = 3;
    localparam int TO = 15;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NP-1:0]     req = '0;
    logic [NP-1:0]     req_write = '0;
    logic [12*NP-1:0]  tag_req = '0;
    logic [5*NP-1:0]   step_done = '0;
    logic [NP-1:0]     instr_done = '0;

    logic [2:0]        step_o;
    logic              cache_reset_o;
    logic [NP-1:0]     grant_o;
    logic [NP-1:0]     read_out_o;
    logic [NP-1:0]     write_out_o;
    logic [11:0]       tag_bus_out_o;
    logic [NP-1:0]     ack_o;
    logic              busy_o;
    logic              bus_error_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rr_m      = NP - 1;
    bit err_m     = 1'b0;

    int dly [1:6];
    bit hit        = 1'b0;
    int stuck_step = 0;
    int stuck_cache = 0;

    snoop_bus_sequencer #(.NUM_PROC(NP), .TIMEOUT(TO)) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .req_i         (req),
        .req_write_i   (req_write),
        .tag_req_i     (tag_req),
        .step_done_i   (step_done),
        .instr_done_i  (instr_done),
        .step_o        (step_o),
        .cache_reset_o (cache_reset_o),
        .grant_o       (grant_o),
        .read_out_o    (read_out_o),
        .write_out_o   (write_out_o),
        .tag_bus_out_o (tag_bus_out_o),
        .ack_o         (ack_o),
        .busy_o        (busy_o),
        .bus_error_o   (bus_error_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caches raise the done for the current step dly[k] cycles after it appears.
    initial begin : responder
        logic [2:0]       prev;
        int               sc;
        int               k;
        logic [5*NP-1:0]  sd;
        logic [NP-1:0]    id;
        prev = 3'd0;
        sc   = 0;
        forever begin
            @(negedge clock);
            if (step_o != prev) sc = 0;
            else sc++;
            prev = step_o;
            sd   = '0;
            id   = '0;
            k    = int'(step_o);
            if (k >= 1 && k <= 6 && sc >= dly[k]) begin
                for (int p = 0; p < NP; p++) begin
                    if (k == 6) begin
                        if (grant_o[p]) id[p] = 1'b1;
                    end else if (k == 2 || k == 5) begin
                        if (grant_o[p]) begin
                            sd[5*p+k-1] = 1'b1;
                            if (k == 2 && hit) id[p] = 1'b1;
                        end
                    end else if (!(stuck_step == k && stuck_cache == p)) begin
                        sd[5*p+k-1] = 1'b1;
                    end
                end
            end
            step_done  = sd;
            instr_done = id;
        end
    end

    task automatic do_txn(input bit drop, input bit mid);
        int          win, n, exp_n, d;
        logic [23:0] seq, exp_seq;
        logic [11:0] exp_tag;
        logic [NP-1:0] oh;
        bit          e, got, changed, exp_wr;
        win = -1;
        for (int i = 1; i <= NP; i++)
            if (win < 0 && req[(rr_m + i) % NP]) win = (rr_m + i) % NP;
        if (win < 0) begin
            total_cnt++;
            $error("FAIL no_request observed=0 expected=1");
            return;
        end
        oh      = NP'(1) << win;
        exp_tag = tag_req[12*win +: 12];
        exp_wr  = req_write[win];
        exp_seq = '0;
        exp_n   = 1;
        e       = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            d = (stuck_step == k) ? 99 : dly[k];
            exp_seq = {exp_seq[20:0], 3'(k)};
            if (d >= TO) begin
                exp_n += TO;
                e = 1'b1;
                break;
            end
            exp_n += d + 1;
            if (k == 2 && hit) break;
        end

        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            got = cache_reset_o;
        end
        chk("cache_reset_seen", 32'(got), 1);
        if (!got) return;
        chk("grant", grant_o, oh);
        chk("tag_latched", tag_bus_out_o, exp_tag);
        chk("read_out", read_out_o, exp_wr ? '0 : oh);
        chk("write_out", write_out_o, exp_wr ? oh : '0);
        chk("busy_in_clr", busy_o, 1);
        chk("step_in_clr", step_o, 0);

        n = 0; seq = '0; got = 1'b0; changed = 1'b0;
        while (!got && n < 200) begin
            @(negedge clock);
            n++;
            if (ack_o != '0) begin
                got = 1'b1;
            end else begin
                if (n == 1) chk("cache_reset_one_cycle", cache_reset_o, 0);
                if (step_o != 3'd0 && step_o != seq[2:0]) seq = {seq[20:0], step_o};
                if (mid && !changed && step_o == 3'd3) begin
                    req[win] = 1'b0;
                    tag_req[12*win +: 12] = ~exp_tag;
                    req_write[win] = ~req_write[win];
                    changed = 1'b1;
                end
            end
        end
        chk("ack_seen", 32'(got), 1);
        chk("ack_target", ack_o, oh);
        chk("txn_cycles", n, exp_n);
        chk("step_sequence", seq, exp_seq);
        err_m = err_m | e;
        chk("bus_error", bus_error_o, 32'(err_m));
        chk("step_in_finish", step_o, 0);
        chk("tag_held", tag_bus_out_o, exp_tag);
        rr_m = win;
        if (drop) req[win] = 1'b0;
        @(negedge clock);
        chk("ack_single_pulse", ack_o, 0);
        chk("grant_released", grant_o, 0);
        chk("busy_released", busy_o, 0);
    endtask

    initial begin : main
        bit seen;
        for (int k = 1; k <= 6; k++) dly[k] = 1;
        repeat (3) @(negedge clock);
        chk("rst_step", step_o, 0);
        chk("rst_cache_reset", cache_reset_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_read", read_out_o, 0);
        chk("rst_write", write_out_o, 0);
        chk("rst_tag", tag_bus_out_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_error", bus_error_o, 0);
        reset = 1'b0;

        // P0 read, each done one cycle after its step
        req = 3'b001; req_write = '0; tag_req[11:0] = 12'h110;
        do_txn(1'b1, 1'b0);

        // done on the last allowed cycle of S4 must not time out
        for (int k = 1; k <= 6; k++) dly[k] = 0;
        dly[4] = TO - 1;
        req = 3'b010; req_write[1] = 1'b1; tag_req[23:12] = 12'hABC;
        do_txn(1'b1, 1'b0);
        dly[4] = 0;

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; rr_m = NP - 1; err_m = 1'b0;

        // all three held: grants 001, 010, 100, 001
        req = 3'b111; req_write = 3'b010;
        tag_req = {12'h333, 12'h222, 12'h111};
        repeat (4) do_txn(1'b0, 1'b0);
        req = '0;

        // P1 read hit ends after S2
        req = 3'b010; req_write = '0; hit = 1'b1;
        do_txn(1'b1, 1'b0);
        hit = 1'b0;

        // P2 write stalls in S3 on cache 0
        req = 3'b100; req_write[2] = 1'b1; tag_req[35:24] = 12'h108;
        stuck_step = 3; stuck_cache = 0;
        do_txn(1'b1, 1'b0);
        stuck_step = 0;
        repeat (3) @(negedge clock);
        chk("bus_error_sticky", bus_error_o, 1);

        // requester drops and changes tag mid-transaction
        req = 3'b010; req_write[1] = 1'b0; tag_req[23:12] = 12'h2A5;
        do_txn(1'b1, 1'b1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (busy_o || cache_reset_o || grant_o != '0) seen = 1'b1;
        end
        chk("no_regrant", 32'(seen), 0);

        // reset lands while in S4
        dly[4] = 3;
        req = 3'b010;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            if (step_o == 3'd4) seen = 1'b1;
        end
        chk("reached_s4", 32'(seen), 1);
        reset = 1'b1; req = '0;
        @(negedge clock);
        chk("abort_step", step_o, 0);
        chk("abort_grant", grant_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_ack", ack_o, 0);
        chk("abort_error", bus_error_o, 0);
        reset = 1'b0; rr_m = NP - 1; err_m = 1'b0;
        dly[4] = 0;
        req = 3'b111;
        do_txn(1'b1, 1'b0);

        for (int it = 0; it < 20; it++) begin
            logic [NP-1:0] nr;
            nr = NP'($urandom_range(1, 7));
            for (int p = 0; p < NP; p++) begin
                if (nr[p] && !req[p]) begin
                    tag_req[12*p +: 12] = 12'($urandom);
                    req_write[p] = 1'($urandom);
                    req[p] = 1'b1;
                end
            end
            for (int k = 1; k <= 6; k++) dly[k] = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) dly[$urandom_range(1, 6)] = $urandom_range(13, 16);
            hit = ($urandom_range(0, 3) == 0);
            do_txn(1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
